// File: rtl/fetch_redirect_unit.sv
// Fetch-stage PC generator with an in-order request tag queue and a small instruction FIFO.
// A decode-stage redirect squashes everything queued or in flight and restarts at the target.
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        target_pc_valid,
    input  logic [31:0] target_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc4
);

    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int QCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TPTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int QPTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [TPTR_W-1:0] TPTR_LAST = TPTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [QPTR_W-1:0] QPTR_LAST = QPTR_W'(FIFO_DEPTH - 1);
    localparam logic [7:0]        DEPTH_W8  = 8'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  MAX_OUT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [QCNT_W-1:0] Q_FULL    = QCNT_W'(FIFO_DEPTH);

    logic [31:0]        pc;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   drop;

    logic [31:0]        tag_addr [MAX_OUTSTANDING];
    logic [TPTR_W-1:0]  tag_wr;
    logic [TPTR_W-1:0]  tag_rd;

    logic [31:0]        q_data [FIFO_DEPTH];
    logic [31:0]        q_pc   [FIFO_DEPTH];
    logic [QPTR_W-1:0]  q_wr;
    logic [QPTR_W-1:0]  q_rd;
    logic [QCNT_W-1:0]  q_count;

    logic [7:0]         credit_used;
    logic               fire;
    logic               resp;
    logic               drop_word;
    logic               push;
    logic               pop;

    // Live (non-squashed) requests plus buffered words must fit in the FIFO, so a push never overflows.
    assign credit_used    = 8'(inflight) - 8'(drop) + 8'(q_count);
    assign imem_req_valid = !reset && !target_pc_valid && (inflight < MAX_OUT)
                            && (credit_used < DEPTH_W8);
    assign imem_req_addr  = reset ? RESET_PC : pc;
    assign fire           = imem_req_valid && imem_req_ready;

    assign resp      = imem_resp_valid && !reset;
    assign drop_word = resp && (drop != '0);
    assign push      = resp && !drop_word && !target_pc_valid;

    assign instr_valid = !reset && !target_pc_valid && (q_count != '0);
    assign pop         = instr_valid && instr_ready;
    assign instr       = instr_valid ? q_data[q_rd] : 32'd0;
    assign instr_pc    = instr_valid ? q_pc[q_rd] : 32'd0;
    assign instr_pc4   = instr_valid ? q_pc[q_rd] + 32'd4 : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
            q_count  <= '0;
        end else begin
            inflight <= inflight + CNT_W'(fire) - CNT_W'(resp);
            if (fire) tag_wr <= (tag_wr == TPTR_LAST) ? '0 : tag_wr + 1'b1;
            if (resp) tag_rd <= (tag_rd == TPTR_LAST) ? '0 : tag_rd + 1'b1;
            if (target_pc_valid) begin
                // Every request still outstanding after this edge belongs to the old path.
                pc      <= target_pc & 32'hFFFF_FFFC;
                drop    <= inflight - CNT_W'(resp);
                q_count <= '0;
                q_wr    <= '0;
                q_rd    <= '0;
            end else begin
                if (fire) pc <= pc + 32'd4;
                if (drop_word) drop <= drop - 1'b1;
                if (push) q_wr <= (q_wr == QPTR_LAST) ? '0 : q_wr + 1'b1;
                if (pop) q_rd <= (q_rd == QPTR_LAST) ? '0 : q_rd + 1'b1;
                q_count <= q_count + QCNT_W'(push) - QCNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire) tag_addr[tag_wr] <= pc;
        if (push) begin
            q_data[q_wr] <= imem_resp_data;
            q_pc[q_wr]   <= tag_addr[tag_rd];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(imem_resp_valid && inflight == '0));
            assert (!(push && q_count == Q_FULL));
            assert (drop <= inflight);
        end
    end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: directed table and corner sequences plus randomized traffic
// checked against a queue-based model of the fetch path and instruction memory.
module tb_fetch_redirect_unit;

    localparam logic [31:0] HI_PC = 32'hFFFF_FFF8;
    localparam int DEPTH = 2;
    localparam int MAXO  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, target_pc_valid, imem_req_ready, imem_resp_valid, instr_ready;
    logic [31:0] target_pc, imem_resp_data;
    logic        imem_req_valid, instr_valid;
    logic [31:0] imem_req_addr, instr, instr_pc, instr_pc4;
    logic        hi_req_valid, hi_instr_valid;
    logic [31:0] hi_req_addr, hi_instr, hi_instr_pc, hi_instr_pc4;

    fetch_redirect_unit u_dut (
        .clk(clk), .reset(reset), .target_pc_valid(target_pc_valid), .target_pc(target_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .instr_pc4(instr_pc4)
    );

    fetch_redirect_unit #(.RESET_PC(HI_PC)) u_hi (
        .clk(clk), .reset(reset), .target_pc_valid(target_pc_valid), .target_pc(target_pc),
        .imem_req_valid(hi_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(hi_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instr_valid(hi_instr_valid), .instr_ready(instr_ready), .instr(hi_instr),
        .instr_pc(hi_instr_pc), .instr_pc4(hi_instr_pc4)
    );

    typedef struct { logic [31:0] addr; int due; bit sq; } req_t;
    typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;
    typedef struct { bit rr; bit ir; bit rv; logic [31:0] addr; bit iv; logic [31:0] ipc; } vec_t;

    req_t        outq[$];
    ent_t        bufq[$];
    logic [31:0] pc_m;
    int          cyc, lat, checks, errors;
    bit          chk_hi;
    bit          s_rv, s_iv;
    logic [31:0] s_addr, s_ipc;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance model state at the edge.
    task automatic cycle(input bit rst, input bit tpv, input logic [31:0] tgt, input bit rr, input bit ir);
        bit   resp, e_rv, e_iv;
        int   live, due;
        ent_t hd, tmp_e;
        req_t r;
        reset = rst; target_pc_valid = tpv; target_pc = tgt; imem_req_ready = rr; instr_ready = ir;
        resp = (outq.size() > 0) && (outq[0].due <= cyc);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mdata(outq[0].addr) : 32'hDEAD_BEEF;
        live = 0;
        foreach (outq[i]) if (!outq[i].sq) live++;
        e_rv = !rst && !tpv && (outq.size() < MAXO) && (live + bufq.size() < DEPTH);
        e_iv = !rst && !tpv && (bufq.size() > 0);
        hd.data = 32'd0; hd.pc = 32'd0;
        if (e_iv) hd = bufq[0];
        #1;
        s_rv = imem_req_valid; s_addr = imem_req_addr; s_iv = instr_valid; s_ipc = instr_pc;
        chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
        if (!rst) chk("req_addr", imem_req_addr, pc_m);
        chk("instr_valid", 32'(instr_valid), 32'(e_iv));
        chk("instr", instr, hd.data);
        chk("instr_pc", instr_pc, hd.pc);
        chk("instr_pc4", instr_pc4, e_iv ? hd.pc + 32'd4 : 32'd0);
        if (chk_hi) begin
            if (!rst) chk("hi_req_addr", hi_req_addr, pc_m + HI_PC);
            chk("hi_instr_pc", hi_instr_pc, e_iv ? hd.pc + HI_PC : 32'd0);
            chk("hi_instr_pc4", hi_instr_pc4, e_iv ? hd.pc + HI_PC + 32'd4 : 32'd0);
        end
        @(posedge clk);
        if (rst) begin
            outq.delete(); bufq.delete(); pc_m = 32'd0;
        end else begin
            if (e_iv && ir) tmp_e = bufq.pop_front();
            if (resp) begin
                r = outq.pop_front();
                if (!r.sq && !tpv) bufq.push_back('{data: mdata(r.addr), pc: r.addr});
            end
            if (tpv) begin
                for (int i = 0; i < outq.size(); i++) begin
                    r = outq[i]; r.sq = 1'b1; outq[i] = r;
                end
                bufq.delete();
                pc_m = tgt & 32'hFFFF_FFFC;
            end else if (e_rv && rr) begin
                due = cyc + lat;
                if (outq.size() > 0 && outq[outq.size()-1].due >= due) due = outq[outq.size()-1].due + 1;
                outq.push_back('{addr: pc_m, due: due, sq: 1'b0});
                pc_m = pc_m + 32'd4;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [8];
        logic [31:0] got [3];
        int          n;
        bit          found;
        checks = 0; errors = 0; cyc = 0; lat = 1; chk_hi = 1'b0; pc_m = 32'd0;
        reset = 1'b1; target_pc_valid = 1'b0; target_pc = 32'd0; imem_req_ready = 1'b0;
        instr_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
        @(posedge clk); #1;

        // Streaming with L=1: the credit rule gives a fetch/fetch/stall rhythm.
        tbl[0] = '{1, 1, 1, 32'h00, 0, 32'h0};
        tbl[1] = '{1, 1, 1, 32'h04, 0, 32'h0};
        tbl[2] = '{1, 1, 0, 32'h08, 1, 32'h0};
        tbl[3] = '{1, 1, 1, 32'h08, 1, 32'h4};
        tbl[4] = '{1, 1, 1, 32'h0C, 0, 32'h0};
        tbl[5] = '{1, 1, 0, 32'h10, 1, 32'h8};
        tbl[6] = '{1, 1, 1, 32'h10, 1, 32'hC};
        tbl[7] = '{1, 1, 1, 32'h14, 0, 32'h0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 32'd0, tbl[i].rr, tbl[i].ir);
            chk($sformatf("t1_rv%0d", i), 32'(s_rv), 32'(tbl[i].rv));
            chk($sformatf("t1_addr%0d", i), s_addr, tbl[i].addr);
            chk($sformatf("t1_iv%0d", i), 32'(s_iv), 32'(tbl[i].iv));
            chk($sformatf("t1_ipc%0d", i), s_ipc, tbl[i].ipc);
        end

        // Decode stall fills the queue, then drains in order.
        do_reset();
        lat = 1;
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("t2_stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t2_stall_instr_valid", 32'(instr_valid), 32'd1);
        chk("t2_stall_instr_pc", instr_pc, 32'd0);
        n = 0;
        for (int k = 0; k < 30 && n < 3; k++) begin
            if (instr_valid) begin got[n] = instr_pc; n++; end
            cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        end
        chk("t2_drain_count", 32'(n), 32'd3);
        for (int i = 0; i < n; i++) chk($sformatf("t2_drain_pc%0d", i), got[i], 32'(4 * i));

        // Redirect with two fetches in flight at L=3.
        do_reset();
        lat = 3;
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b1);
        target_pc_valid = 1'b0; #1;
        chk("t3_redir_addr", imem_req_addr, 32'h100);
        chk("t3_redir_iv", 32'(instr_valid), 32'd0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
            if (instr_valid) begin
                found = 1'b1;
                chk("t3_first_pc", instr_pc, 32'h100);
            end
        end
        if (!found) chk("t3_first_pc_timeout", 32'd0, 32'd1);

        // Redirect coinciding with a response and a held instruction.
        do_reset();
        lat = 2;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("t4_held_iv", 32'(instr_valid), 32'd1);
        cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
        target_pc_valid = 1'b0; #1;
        chk("t4_fifo_empty", 32'(instr_valid), 32'd0);
        chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t4_req_addr", imem_req_addr, 32'h200);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

        // PC wrap from a high reset address.
        do_reset();
        lat = 1;
        chk_hi = 1'b1;
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("t5_addr1", hi_req_addr, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("t5_addr2", hi_req_addr, 32'h0000_0000);
        chk("t5_pc_a", hi_instr_pc, 32'hFFFF_FFF8);
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("t5_pc_b", hi_instr_pc, 32'hFFFF_FFFC);
        chk("t5_pc4_b", hi_instr_pc4, 32'h0000_0000);
        chk_hi = 1'b0;

        // Reset mid-burst with requests in flight and a full queue.
        do_reset();
        lat = 3;
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        reset = 1'b0; #1;
        chk("t6_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_req_addr", imem_req_addr, 32'd0);
        chk("t6_iv", 32'(instr_valid), 32'd0);
        chk("t6_instr", instr, 32'd0);
        chk("t6_instr_pc4", instr_pc4, 32'd0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

        // Randomized traffic.
        do_reset();
        for (int seg = 0; seg < 12; seg++) begin
            lat = int'($urandom_range(1, 4));
            for (int i = 0; i < 50; i++) begin
                cycle(($urandom % 150) == 0, ($urandom % 10) == 0, $urandom,
                      ($urandom % 4) != 0, ($urandom % 3) != 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
